// File: rtl/nes_attr_reader_if.sv
// Purpose : request/result/ROM bundle between the background renderer and nes_attr_reader.
// Latency : n/a (wires only).
// Backpressure: busy tells the requester that a req will be ignored.
// Ports   : req/tile_col/tile_row/inval  renderer -> reader
//           busy/valid/pal_sel           reader   -> renderer
//           rom_addr                     reader   -> attribute ROM
//           rom_dout                     attribute ROM -> reader
interface nes_attr_reader_if #(
  parameter int AW = 7,
  parameter int DW = 8
);
  logic          req;
  logic [4:0]    tile_col;
  logic [4:0]    tile_row;
  logic          inval;
  logic          busy;
  logic          valid;
  logic [1:0]    pal_sel;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;

  // slave: the reader itself
  modport slave (
    input  req, tile_col, tile_row, inval, rom_dout,
    output busy, valid, pal_sel, rom_addr
  );

  // master: renderer plus ROM environment
  modport master (
    output req, tile_col, tile_row, inval, rom_dout,
    input  busy, valid, pal_sel, rom_addr
  );
endinterface

// File: rtl/nes_attr_reader.sv
// Purpose : fetch an NES attribute byte for a tile and return its 2-bit palette select.
// Latency : 1 cycle on a cache hit, ROM_LAT+2 cycles on a miss.
// Backpressure: req is ignored (not queued) while busy=1; requester re-issues.
// Ports   : clk, rst (sync, active-low); bus = nes_attr_reader_if.slave
//           (req/tile_col/tile_row/inval in, busy/valid/pal_sel/rom_addr out, rom_dout in).
module nes_attr_reader #(
  parameter int AW       = 7,
  parameter int DW       = 8,
  parameter int ROM_LAT  = 1,
  parameter int CACHE_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  nes_attr_reader_if.slave bus
);

  // Wait counter only has to hold ROM_LAT-1 (0..2).
  localparam int            CW       = (ROM_LAT > 2) ? 2 : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ROM_LAT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [1:0]    pal_q, pal_d;
  logic [5:0]    addr_q, addr_d;
  logic [1:0]    quad_q, quad_d;
  logic          poison_q, poison_d;   // inval seen while this fetch was in flight
  logic          cache_v_q, cache_v_d;
  logic [5:0]    cache_a_q, cache_a_d;
  logic [DW-1:0] cache_d_q, cache_d_d;

  // One attribute byte covers a 4x4-tile block; bit 1 of row/col picks the 2x2 quadrant.
  logic [5:0] req_a;
  logic [1:0] req_q;
  logic       hit;
  logic [1:0] cache_pal;
  logic [1:0] rom_pal;

  assign req_a     = {bus.tile_row[4:2], bus.tile_col[4:2]};
  assign req_q     = {bus.tile_row[1], bus.tile_col[1]};
  assign hit       = (CACHE_EN != 0) && cache_v_q && (cache_a_q == req_a) && !bus.inval;
  assign cache_pal = cache_d_q[{req_q, 1'b0} +: 2];
  assign rom_pal   = bus.rom_dout[{quad_q, 1'b0} +: 2];

  // Tile-within-quadrant bits do not affect the attribute lookup.
  logic unused_lsb;
  assign unused_lsb = ^{bus.tile_row[0], bus.tile_col[0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    pal_d     = pal_q;
    addr_d    = addr_q;
    quad_d    = quad_q;
    poison_d  = poison_q;
    cache_v_d = cache_v_q;
    cache_a_d = cache_a_q;
    cache_d_d = cache_d_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          if (hit) begin
            valid_d = 1'b1;
            pal_d   = cache_pal;
          end else begin
            // An inval that forced this miss predates the ROM read, so it
            // does not stop the returned byte from being cached.
            addr_d   = req_a;
            quad_d   = req_q;
            busy_d   = 1'b1;
            cnt_d    = CNT_INIT;
            poison_d = 1'b0;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.inval) poison_d = 1'b1;
        if (cnt_q == '0) state_d = S_CAPT;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_CAPT: begin
        pal_d   = rom_pal;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if ((CACHE_EN != 0) && !poison_q && !bus.inval) begin
          cache_v_d = 1'b1;
          cache_a_d = addr_q;
          cache_d_d = bus.rom_dout;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Flush wins over any fill in the same cycle.
    if (bus.inval)      cache_v_d = 1'b0;
    if (CACHE_EN == 0)  cache_v_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      pal_q     <= 2'b00;
      addr_q    <= '0;
      quad_q    <= 2'b00;
      poison_q  <= 1'b0;
      cache_v_q <= 1'b0;
      cache_a_q <= '0;
      cache_d_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      pal_q     <= pal_d;
      addr_q    <= addr_d;
      quad_q    <= quad_d;
      poison_q  <= poison_d;
      cache_v_q <= cache_v_d;
      cache_a_q <= cache_a_d;
      cache_d_q <= cache_d_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.pal_sel  = pal_q;
  assign bus.rom_addr = AW'(addr_q);

endmodule

// File: tb/tb_nes_attr_reader.sv
// Purpose : drive two readers (ROM_LAT=1 and ROM_LAT=2) with identical stimulus and check them.
// Latency : expected 1 (hit) / ROM_LAT+2 (miss), checked per instance.
// Backpressure: requests issued while an instance is busy are dropped by it and by its model.
module tb_nes_attr_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_r   = 1'b0;
  logic       req_r   = 1'b0;
  logic       inval_r = 1'b0;
  logic [4:0] row_r   = 5'd0;
  logic [4:0] col_r   = 5'd0;

  logic [7:0] rom [128];
  logic [7:0] rom0_q = 8'h00;
  logic [7:0] rom1a_q = 8'h00;
  logic [7:0] rom1b_q = 8'h00;

  nes_attr_reader_if #(.AW(7), .DW(8)) if0 ();
  nes_attr_reader_if #(.AW(7), .DW(8)) if1 ();

  assign if0.req = req_r;  assign if0.inval = inval_r;
  assign if0.tile_row = row_r;  assign if0.tile_col = col_r;
  assign if0.rom_dout = rom0_q;
  assign if1.req = req_r;  assign if1.inval = inval_r;
  assign if1.tile_row = row_r;  assign if1.tile_col = col_r;
  assign if1.rom_dout = rom1b_q;

  nes_attr_reader #(.AW(7), .DW(8), .ROM_LAT(1), .CACHE_EN(1)) u_dut0 (
    .clk(clk), .rst(rst_r), .bus(if0));
  nes_attr_reader #(.AW(7), .DW(8), .ROM_LAT(2), .CACHE_EN(1)) u_dut1 (
    .clk(clk), .rst(rst_r), .bus(if1));

  // Registered-read ROMs with 1 and 2 cycles of latency.
  always @(posedge clk) begin
    rom0_q  <= rom[if0.rom_addr];
    rom1a_q <= rom[if1.rom_addr];
    rom1b_q <= rom1a_q;
  end

  logic [1:0] o_valid, o_busy;
  logic [1:0] o_pal  [2];
  logic [6:0] o_addr [2];
  assign o_valid = {if1.valid, if0.valid};
  assign o_busy  = {if1.busy, if0.busy};
  assign o_pal[0] = if0.pal_sel;   assign o_pal[1] = if1.pal_sel;
  assign o_addr[0] = if0.rom_addr; assign o_addr[1] = if1.rom_addr;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         lat_p [2] = '{1, 2};
  bit         m_busy [2];
  int         m_left [2];     // edges remaining until the capture edge
  logic [1:0] m_fq [2];
  bit         m_poison [2];
  bit         m_cv [2];
  logic [5:0] m_ca [2];
  logic [7:0] m_cd [2];
  bit         m_vld [2];
  logic [1:0] m_pal [2];
  logic [6:0] m_addr [2];

  function automatic logic [1:0] pal_of(input logic [7:0] b, input int q);
    return 2'((b >> (2 * q)) & 8'd3);
  endfunction

  function automatic int blk_of(input int row, input int col);
    return (row / 4) * 8 + (col / 4);
  endfunction

  function automatic int quad_of(input int row, input int col);
    return ((row / 2) % 2) * 2 + ((col / 2) % 2);
  endfunction

  task automatic model_edge();
    int a, q;
    logic [7:0] d;
    a = blk_of(int'(row_r), int'(col_r));
    q = quad_of(int'(row_r), int'(col_r));
    for (int i = 0; i < 2; i++) begin
      m_vld[i] = 1'b0;
      if (!rst_r) begin
        m_busy[i] = 0; m_left[i] = 0; m_poison[i] = 0; m_cv[i] = 0;
        m_ca[i] = '0; m_cd[i] = '0; m_pal[i] = '0; m_addr[i] = '0; m_fq[i] = '0;
      end else begin
        if (m_busy[i]) begin
          m_left[i]--;
          if (inval_r) m_poison[i] = 1;
          if (m_left[i] == 0) begin
            d = rom[m_addr[i]];
            m_pal[i]  = pal_of(d, int'(m_fq[i]));
            m_vld[i]  = 1;
            m_busy[i] = 0;
            if (!m_poison[i]) begin
              m_cv[i] = 1; m_ca[i] = m_addr[i][5:0]; m_cd[i] = d;
            end
          end
        end else if (req_r) begin
          if (m_cv[i] && int'(m_ca[i]) == a && !inval_r) begin
            m_vld[i] = 1;
            m_pal[i] = pal_of(m_cd[i], q);
          end else begin
            m_busy[i]   = 1;
            m_left[i]   = lat_p[i] + 1;
            m_addr[i]   = 7'(a);
            m_fq[i]     = 2'(q);
            m_poison[i] = 0;
          end
        end
        if (inval_r) m_cv[i] = 0;
      end
    end
  endtask

  // One clock: advance model at the edge, compare both instances 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid[%0d]", i), o_valid[i], m_vld[i]);
      chk($sformatf("busy[%0d]", i), o_busy[i], m_busy[i]);
      chk($sformatf("pal_sel[%0d]", i), o_pal[i], m_pal[i]);
      chk($sformatf("rom_addr[%0d]", i), o_addr[i], m_addr[i]);
    end
  endtask

  // Issue one request and measure the valid latency of each instance.
  task automatic rq(input int row, input int col, input bit inv, input bit inv_wait,
                    output int lat0, output int lat1,
                    output logic [1:0] p0, output logic [1:0] p1);
    row_r = 5'(row); col_r = 5'(col); req_r = 1'b1; inval_r = inv;
    lat0 = -1; lat1 = -1; p0 = 2'b00; p1 = 2'b00;
    for (int c = 1; c <= 12; c++) begin
      step();
      req_r   = 1'b0;
      inval_r = inv_wait && (c == 1);
      if (o_valid[0] && lat0 < 0) begin lat0 = c; p0 = o_pal[0]; end
      if (o_valid[1] && lat1 < 0) begin lat1 = c; p1 = o_pal[1]; end
      if (lat0 >= 0 && lat1 >= 0) break;
    end
    inval_r = 1'b0;
  endtask

  task automatic dir(input string tag, input int row, input int col, input bit inv,
                     input bit inv_wait, input int el0, input int el1, input int epal);
    int l0, l1;
    logic [1:0] p0, p1;
    rq(row, col, inv, inv_wait, l0, l1, p0, p1);
    chk({tag, ".lat0"}, 32'(l0), 32'(el0));
    chk({tag, ".lat1"}, 32'(l1), 32'(el1));
    chk({tag, ".pal0"}, p0, 32'(epal));
    chk({tag, ".pal1"}, p1, 32'(epal));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 8'((i * 37 + 11) & 255);
    rom[0] = 8'h15; rom[5] = 8'h45; rom[9] = 8'h40; rom[33] = 8'h00;

    // reset
    rst_r = 1'b0;
    step(); step();
    for (int i = 0; i < 2; i++) begin
      chk("rst.valid", o_valid[i], 0);
      chk("rst.busy", o_busy[i], 0);
      chk("rst.pal", o_pal[i], 0);
      chk("rst.addr", o_addr[i], 0);
    end
    rst_r = 1'b1;
    step();

    dir("miss00", 0, 0, 0, 0, 3, 4, 1);
    chk("miss00.addr", o_addr[0], 0);
    dir("hit22", 2, 2, 0, 0, 1, 1, 0);
    chk("hit22.addr", o_addr[0], 0);
    dir("miss66", 6, 6, 0, 0, 3, 4, 1);
    chk("miss66.addr", o_addr[1], 9);
    dir("hit44", 4, 4, 0, 0, 1, 1, 0);

    dir("q.TL", 0, 20, 0, 0, 3, 4, 1);
    dir("q.TR", 0, 22, 0, 0, 1, 1, 1);
    dir("q.BL", 2, 20, 0, 0, 1, 1, 0);
    dir("q.BR", 2, 22, 0, 0, 1, 1, 1);
    dir("r16c4", 16, 4, 0, 0, 3, 4, 0);
    chk("r16c4.addr", o_addr[0], 33);

    dir("fill00", 0, 0, 0, 0, 3, 4, 1);
    dir("rehit00", 0, 0, 0, 0, 1, 1, 1);
    dir("inval00", 0, 0, 1, 1, 3, 4, 1);
    dir("after_inval", 0, 0, 0, 0, 3, 4, 1);
    dir("refilled", 0, 0, 0, 0, 1, 1, 1);

    // reset while both instances are waiting on the ROM
    row_r = 5'd8; col_r = 5'd8; req_r = 1'b1;
    step();
    req_r = 1'b0;
    chk("pre_rst.busy", o_busy, 2'b11);
    rst_r = 1'b0;
    step();
    chk("midrst.busy", o_busy, 0);
    chk("midrst.addr0", o_addr[0], 0);
    chk("midrst.addr1", o_addr[1], 0);
    rst_r = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("postrst.novalid", o_valid, 0);
    end
    dir("rst_miss", 8, 8, 0, 0, 3, 4, int'(pal_of(rom[18], 0)));
    chk("rst_miss.addr", o_addr[1], 18);
    dir("rst_miss_hit", 8, 8, 0, 0, 1, 1, int'(pal_of(rom[18], 0)));

    // randomized traffic, biased toward nearby tiles so hits are common
    for (int n = 0; n < 4000; n++) begin
      rst_r   = ($urandom_range(0, 299) != 0);
      req_r   = 1'($urandom_range(0, 1));
      inval_r = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) begin
        row_r = 5'($urandom_range(0, 31));
        col_r = 5'($urandom_range(0, 31));
      end else begin
        row_r = {row_r[4:2], 2'($urandom_range(0, 3))};
        col_r = {col_r[4:2], 2'($urandom_range(0, 3))};
      end
      step();
    end
    req_r = 1'b0; inval_r = 1'b0; rst_r = 1'b1;
    for (int k = 0; k < 6; k++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nes_attr_reader.md
Name: nes_attr_reader

Overview:
- Client-side reader for the NES attribute-table ROMs (`ROM_ATABLE_*`: 128x8, 1-cycle registered read).
- Accepts a tile coordinate request from the background renderer and drives the ROM address.
- Captures the returned attribute byte and extracts the 2-bit palette select for that tile's 16x16 quadrant.
- A one-entry byte cache makes repeat hits within the same 32x32 block take 1 cycle instead of a full ROM fetch.

Parameters:
- AW, 7, ROM address width; the upper bits above 6 are driven 0.
- DW, 8, ROM data width; fixed at 8. Any other value is unsupported.
- ROM_LAT, 1, ROM read latency in cycles, 1..3. The wait counter is sized for it.
- CACHE_EN, 1, 1 = one-entry cache enabled; 0 = every request is a miss.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  1  request strobe; sampled only when busy=0.
- tile_col  in  5  tile column 0..31.
- tile_row  in  5  tile row 0..31; rows 30/31 are legal and map to attribute row 7.
- inval  in  1  1-cycle pulse that flushes the cache.
- busy  out  1  high while a ROM fetch is in flight.
- valid  out  1  1-cycle pulse; pal_sel is valid while it is high.
- pal_sel  out  2  palette select for the requested tile.
- rom_addr  out  AW  registered address to the ROM.
- rom_dout  in  DW  ROM data, valid ROM_LAT cycles after rom_addr changes.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, busy=0, valid=0, pal_sel=0, rom_addr=0, wait counter=0, cache_valid=0, cache_addr=0, cache_data=0. Reset overrides any in-flight fetch; no valid pulse follows.
- Address: a = {tile_row[4:2], tile_col[4:2]}, giving 0..63. rom_addr = {(AW-6)'b0, a}.
- Quadrant: q = {tile_row[1], tile_col[1]}; pal_sel = byte[2q+1:2q].
  - q=0: TL, bits 1:0.
  - q=1: TR, bits 3:2.
  - q=2: BL, bits 5:4.
  - q=3: BR, bits 7:6.
- States: IDLE, WAIT, CAPT.
- IDLE:
  - If req=1 and it is a hit (CACHE_EN=1, cache_valid=1, cache_addr==a, inval=0): stay in IDLE. At this edge register valid=1 and pal_sel from cache_data. Latency 1 cycle.
  - If req=1 and it is a miss: register rom_addr=a, latch q, set busy=1, load counter=ROM_LAT-1, go to WAIT.
- WAIT: decrement the counter. When it reaches 0, go to CAPT.
- CAPT:
  - Sample rom_dout and register pal_sel from it; valid=1 and busy=0 for one cycle; return to IDLE.
  - If no inval was seen during this fetch: cache_data=rom_dout, cache_addr=a, cache_valid=1.
  - Miss latency is ROM_LAT+2 cycles from the req cycle to the valid cycle, i.e. 3 with the default.
- valid is a strict 1-cycle pulse. pal_sel holds its last value between pulses.
- Back-to-back requests: a req in the cycle where valid=1 is accepted (state is IDLE). Sustained hits give one result per cycle.
- A req while busy=1 is ignored and not queued; the requester must hold or re-issue it.
- rom_addr holds its value between fetches and is not cleared on return to IDLE.
- inval:
  - Clears cache_valid at the edge it is sampled, in any state.
  - An inval in the same cycle as a req in IDLE forces that req to be a miss.
  - An inval during WAIT or CAPT lets the in-flight fetch complete and return its data, but the data is not cached (cache_valid stays 0).
- CACHE_EN=0: cache_valid is tied to 0; every request takes ROM_LAT+2 cycles.

Test Plan:
- Reset, then req at (row 0, col 0) with the sprilo table 0 ROM (addr 0 = 0x15) -> rom_addr=0; busy=1 for 2 cycles; valid in cycle 3 with pal_sel=01.
- Next cycle req at (row 2, col 2), same block -> cache hit; valid in the next cycle with pal_sel=00; rom_addr unchanged; busy never asserts.
- req at (row 6, col 6) (addr 9 = 0x40) -> miss, pal_sel=01 after 3 cycles. Then (row 4, col 4) -> hit, pal_sel=00.
- Quadrant sweep on addr 5 (0x45) at (row 0/2, col 20/22):
  - TL=01, TR=01, BL=00, BR=01.
  - (row 16, col 4) reads addr 33 (0x00) -> pal_sel=00.
- Hit request at (row 0, col 0) with inval=1 in the same cycle -> treated as a miss (busy asserts, 3-cycle latency). A second inval during WAIT -> data still returned, then the next same-block request misses.
- Hold rst=0 during WAIT of a fetch -> no valid pulse; busy=0 and rom_addr=0 after the edge; the first request after reset is a miss. Repeat with ROM_LAT=2 -> miss latency 4.
